// File: rtl/stego_pkg.sv
// Shared types and constants for the LSB embedding sequencer.
package stego_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmbed,
    StPass,
    StDone
  } state_e;

  // 32x32x3 image frame.
  localparam int unsigned PIXEL_BYTES_DEFAULT = 3072;
  // Longest message the system issues. This bound is informational only.
  localparam int unsigned MAX_MSG_BITS = 1040;

  // Counter width that can hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lsb_embed_stage.sv
// One-entry output register: captures an embedded or passed-through byte and holds it under
// downstream backpressure.
module lsb_embed_stage (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       embed_en_i,
  input  logic       bit_i,
  input  logic [7:0] pix_data_i,
  input  logic       last_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  output logic       can_load_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  assign can_load_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

  // Load a new byte, drain on handshake, otherwise hold everything stable.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = embed_en_i ? {pix_data_i[7:1], bit_i} : pix_data_i;
      last_d  = last_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/lsb_embed_sequencer.sv
// Streams one image frame byte by byte and overwrites bit 0 of the first msg_len bytes with
// message bits, MSB first. The remaining bytes pass through unchanged.
module lsb_embed_sequencer
  import stego_pkg::*;
#(
  parameter int unsigned PIXEL_BYTES = PIXEL_BYTES_DEFAULT,
  parameter int unsigned CNT_W       = cnt_w(PIXEL_BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] msg_len,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_data,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [7:0]       msg_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] PixMax  = CNT_W'(PIXEL_BYTES);
  localparam logic [CNT_W-1:0] PixLast = CNT_W'(PIXEL_BYTES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] msg_len_q, msg_len_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [7:0]       sh_q, sh_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic can_load;
  logic pix_acc;
  logic msg_hs;
  logic is_last_byte;

  assign pix_ready    = can_load && ((state_q == StPass) ||
                                     ((state_q == StEmbed) && (bcnt_q != 4'd0)));
  // Refill only when the buffered character is exhausted; this costs one bubble per 8 bytes.
  assign msg_ready    = (state_q == StEmbed) && (bcnt_q == 4'd0);
  assign pix_acc      = pix_valid && pix_ready;
  assign msg_hs       = msg_valid && msg_ready;
  assign is_last_byte = (byte_cnt_q == PixLast);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;

  lsb_embed_stage u_stage (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (pix_acc),
    .embed_en_i  (state_q == StEmbed),
    .bit_i       (sh_q[7]),
    .pix_data_i  (pix_data),
    .last_i      (is_last_byte),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .can_load_o  (can_load)
  );

  // Next-state logic: frame sequencing, bit serialisation and the byte/bit counters.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    msg_len_d  = msg_len_q;
    bcnt_d     = bcnt_q;
    sh_d       = sh_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (msg_len > PixMax) begin
            err_d = 1'b1;
          end else begin
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            bcnt_d     = 4'd0;
            sh_d       = 8'h00;
            msg_len_d  = msg_len;
            state_d    = (msg_len == '0) ? StPass : StEmbed;
          end
        end
      end
      StEmbed: begin
        if (msg_hs) begin
          sh_d   = msg_data;
          bcnt_d = 4'd8;
        end else if (pix_acc) begin
          byte_cnt_d = byte_cnt_q + CntOne;
          bit_cnt_d  = bit_cnt_q + CntOne;
          sh_d       = {sh_q[6:0], 1'b0};
          bcnt_d     = bcnt_q - 4'd1;
          if (is_last_byte) begin
            state_d = StDone;
            bcnt_d  = 4'd0;
          end else if ((bit_cnt_q + CntOne) == msg_len_q) begin
            // Remaining bits of a partial last character are dropped here.
            state_d = StPass;
            bcnt_d  = 4'd0;
          end
        end
      end
      StPass: begin
        if (pix_acc) begin
          byte_cnt_d = byte_cnt_q + CntOne;
          if (is_last_byte) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_valid && out_ready && out_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      msg_len_q  <= '0;
      bcnt_q     <= 4'd0;
      sh_q       <= 8'h00;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      msg_len_q  <= msg_len_d;
      bcnt_q     <= bcnt_d;
      sh_q       <= sh_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_lsb_embed_sequencer.sv
// Directed bench for lsb_embed_sequencer with a 32-byte frame.
module tb_lsb_embed_sequencer;

  localparam int unsigned PB = 32;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] msg_len;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          msg_valid;
  logic          msg_ready;
  logic [7:0]    msg_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  lsb_embed_sequencer #(
    .PIXEL_BYTES (PB),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .msg_len   (msg_len),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pix_mem [PB];
  logic [7:0] exp_mem [PB];
  logic [7:0] msg_mem [4];
  int         n_chars;

  logic [7:0] got_data [$];
  logic       got_last [$];
  int         msg_hs_cnt, done_cnt, done_cyc, last_cyc, late_msg_ready;
  int         pix_idx, msg_idx, stall_left;
  bit         stall_started;

  // Test 1 vectors: chars A5,3C over 0xFF pixels, 16 bits embedded.
  task automatic load_vec_a5_3c();
    logic [7:0] e [16];
    e = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFE, 8'hFF,
          8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE};
    for (int i = 0; i < PB; i++) begin
      pix_mem[i] = 8'hFF;
      exp_mem[i] = (i < 16) ? e[i] : 8'hFF;
    end
    msg_mem[0] = 8'hA5;
    msg_mem[1] = 8'h3C;
    n_chars    = 2;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset     = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    msg_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; returns early once reset_after outputs have been collected.
  task automatic run_frame(input logic [CW-1:0] len, input int stall_at, input int reset_after);
    got_data.delete();
    got_last.delete();
    msg_hs_cnt     = 0;
    done_cnt       = 0;
    done_cyc       = -10;
    last_cyc       = -10;
    late_msg_ready = 0;
    pix_idx        = 0;
    msg_idx        = 0;
    stall_left     = 0;
    stall_started  = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    msg_len   = len;
    out_ready = 1'b1;
    pix_valid = 1'b0;
    msg_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pix_valid = (pix_idx < PB);
      pix_data  = pix_valid ? pix_mem[pix_idx] : 8'h00;
      msg_valid = (msg_idx < n_chars);
      msg_data  = msg_valid ? msg_mem[msg_idx] : 8'h00;
      if (stall_at >= 0 && !stall_started && got_data.size() == stall_at) begin
        stall_started = 1'b1;
        stall_left    = 5;
      end
      out_ready = (stall_left == 0);
      #1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!out_ready && out_valid) begin
        check_eq($sformatf("stall_data[%0d]", got_data.size()), out_data,
                 exp_mem[got_data.size()]);
        check_eq("stall_last", out_last, got_data.size() == PB - 1);
        check_eq("stall_pix_ready", pix_ready, 0);
      end
      if (msg_ready && msg_idx >= n_chars) late_msg_ready++;
      if (msg_valid && msg_ready) begin
        msg_idx++;
        msg_hs_cnt++;
      end
      if (pix_valid && pix_ready) pix_idx++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last) last_cyc = cyc;
      end
      if (stall_left > 0) stall_left--;
      if (reset_after >= 0 && got_data.size() == reset_after) return;
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    msg_valid = 1'b0;
  endtask

  task automatic verify_frame(input string name, input int exp_hs);
    check_eq({name, "_count"}, got_data.size(), PB);
    for (int i = 0; i < got_data.size() && i < PB; i++) begin
      check_eq($sformatf("%s_data[%0d]", name, i), got_data[i], exp_mem[i]);
      check_eq($sformatf("%s_last[%0d]", name, i), got_last[i], i == PB - 1);
    end
    check_eq({name, "_done_cnt"}, done_cnt, 1);
    check_eq({name, "_done_lat"}, done_cyc - last_cyc, 1);
    check_eq({name, "_msg_hs"}, msg_hs_cnt, exp_hs);
    check_eq({name, "_late_msg_ready"}, late_msg_ready, 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    msg_len   = '0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    msg_valid = 1'b0;
    msg_data  = 8'h00;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pix_ready", pix_ready, 0);
    check_eq("rst_msg_ready", msg_ready, 0);
    check_eq("rst_done_err", {done, err}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: two characters embedded, rest passed through.
    load_vec_a5_3c();
    run_frame(6'd16, -1, -1);
    verify_frame("t1", 2);

    // Test 2: zero-length message is a plain copy.
    for (int i = 0; i < PB; i++) begin
      pix_mem[i] = 8'(i);
      exp_mem[i] = 8'(i);
    end
    n_chars = 0;
    run_frame(6'd0, -1, -1);
    verify_frame("t2", 0);

    // Test 3: oversized message is rejected, then an 8-bit frame runs.
    @(negedge clk);
    start     = 1'b1;
    msg_len   = 6'd33;
    pix_valid = 1'b1;
    msg_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("t3_err", err, 1);
    check_eq("t3_busy", busy, 0);
    check_eq("t3_pix_ready", pix_ready, 0);
    check_eq("t3_msg_ready", msg_ready, 0);
    @(negedge clk);
    #1;
    check_eq("t3_err_pulse", err, 0);
    pix_valid = 1'b0;
    msg_valid = 1'b0;
    begin
      logic [7:0] e [8];
      e = '{8'h80, 8'h81, 8'h80, 8'h81, 8'h81, 8'h80, 8'h81, 8'h80};
      for (int i = 0; i < PB; i++) begin
        pix_mem[i] = 8'h80;
        exp_mem[i] = (i < 8) ? e[i] : 8'h80;
      end
    end
    msg_mem[0] = 8'h5A;
    n_chars    = 1;
    run_frame(6'd8, -1, -1);
    verify_frame("t3", 1);

    // Test 4: output stalled for 5 cycles mid-frame.
    load_vec_a5_3c();
    run_frame(6'd16, 10, -1);
    check_eq("t4_stalled", stall_started, 1);
    verify_frame("t4", 2);

    // Test 5: partial last character, extra bits dropped.
    for (int i = 0; i < PB; i++) begin
      pix_mem[i] = 8'hAA;
      exp_mem[i] = (i == 8 || i == 9) ? 8'hAB : 8'hAA;
    end
    msg_mem[0] = 8'h00;
    msg_mem[1] = 8'hC0;
    msg_mem[2] = 8'hFF;
    n_chars    = 3;
    run_frame(6'd10, -1, -1);
    verify_frame("t5", 2);

    // Test 6: reset mid-frame, then a complete frame.
    load_vec_a5_3c();
    run_frame(6'd16, -1, 5);
    check_eq("t6_reached5", got_data.size(), 5);
    reset_dut();
    check_eq("t6_out_valid", out_valid, 0);
    check_eq("t6_out_data", out_data, 0);
    check_eq("t6_out_last", out_last, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_ready", {pix_ready, msg_ready}, 0);
    check_eq("t6_done_err", {done, err}, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(6'd16, -1, -1);
    verify_frame("t6", 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lsb_embed_sequencer.md
Name: lsb_embed_sequencer

Overview:
Streaming controller that sequences LSB steganographic embedding over one image frame.
- Accepts image bytes on a valid/ready stream and message characters on a second valid/ready stream.
- Serializes characters MSB-first into one bit per image byte and overwrites bit 0 of the first msg_len bytes.
- Passes the remaining bytes unchanged, then signals done.
- Sits between the image-memory reader and the output writer; replaces the all-parallel embed with a one-byte-per-cycle pipeline.

Parameters:
PIXEL_BYTES, 3072, image bytes per frame (32x32x3)
MAX_MSG_BITS, 1040, largest message length the system issues (documentation/assertion bound only)
CNT_W, $clog2(PIXEL_BYTES+1), width of byte and bit counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins a frame (honoured in IDLE only)
msg_len  in  CNT_W  message length in bits; sampled on start
pix_valid  in  1  image byte available
pix_ready  out  1  image byte accepted when pix_valid && pix_ready
pix_data  in  8  image byte
msg_valid  in  1  message character available
msg_ready  out  1  character accepted when msg_valid && msg_ready
msg_data  in  8  message character, bit 7 embedded first
out_valid  out  1  output byte valid
out_ready  in  1  downstream accepts output byte
out_data  out  8  embedded or passed-through byte
out_last  out  1  marks final byte of frame (with out_valid)
busy  out  1  high in EMBED, PASS and DONE
done  out  1  one-cycle pulse when frame fully drained
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; byte_cnt, bit_cnt, bcnt (buffered bits) cleared; shift register cleared.
  - Reset mid-frame discards everything in flight. The bench must also reset or flush the upstream sources.
- States: IDLE, EMBED, PASS, DONE.
- IDLE:
  - start && msg_len > PIXEL_BYTES: err=1 next cycle, stay IDLE.
  - start && msg_len == 0: go to PASS.
  - Otherwise start goes to EMBED; msg_len is latched.
  - start outside IDLE is ignored; no err.
- Output register (one entry):
  - Can load when !out_valid || out_ready.
  - pix_ready = can_load && (state==PASS || (state==EMBED && bcnt!=0)).
- Pixel acceptance latency: one cycle to out_valid.
- out_data:
  - EMBED: {pix_data[7:1], sh[7]}; sh shifts left by one and bcnt decrements on each accept.
  - PASS: pix_data unchanged.
- msg_ready = (state==EMBED) && bcnt==0.
  - On handshake: sh <= msg_data, bcnt <= 8.
  - This gives one bubble cycle per 8 embedded bytes; no pixel is accepted while bcnt==0.
- bit_cnt increments per embedded byte.
  - When the accept makes bit_cnt == msg_len_q: go to PASS and clear bcnt.
  - Unused bits of a partial last character are discarded; msg_ready does not reassert.
- byte_cnt increments per accepted pixel.
  - On the accept making byte_cnt == PIXEL_BYTES: out_last is loaded with that byte, pix_ready drops, go to DONE.
  - Applies in EMBED too, when msg_len == PIXEL_BYTES.
- DONE:
  - Wait until out_valid && out_ready with out_last.
  - Pulse done the following cycle, go to IDLE.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable and no input is accepted.
- Simultaneous events: reset has priority over all; a message handshake and a pixel accept never occur in the same cycle by construction.

Decomposition:
Package stego_pkg holds:
- state enum (IDLE, EMBED, PASS, DONE)
- PIXEL_BYTES default, MAX_MSG_BITS, CNT_W function

Sub-module lsb_embed_stage holds the one-entry output register:
- Inputs: load, embed_en, bit, pix_data, last, out_ready.
- Outputs: out_valid/out_data/out_last, can_load.

Test Plan:
1. PIXEL_BYTES=32, msg_len=16, chars 0xA5,0x3C, all pixels 0xFF, out_ready=1 -> out bytes 0-15 = FF FE FF FE FE FF FE FF FE FE FF FF FF FF FE FE; bytes 16-31 = FF; out_last on byte 31; done one cycle after it drains; exactly 2 msg handshakes.
2. msg_len=0, pixels 0x00..0x1F -> outputs identical to inputs; msg_ready never asserts; done pulses once.
3. msg_len=33 with PIXEL_BYTES=32 -> err=1 for one cycle; busy, pix_ready and msg_ready stay 0; next start with msg_len=8 proceeds normally.
4. Mid-frame, out_ready low for 5 cycles -> out_data/out_last held constant, pix_ready=0; no byte lost or duplicated over the whole frame (32 outputs).
5. msg_len=10, chars 0x00,0xC0, pixels 0xAA -> bytes 0-7 = AA; bytes 8,9 = AB; bytes 10-31 = AA; msg_ready never asserts after the second char.
6. reset asserted after 5 outputs -> next cycle all outputs 0, state IDLE; a fresh start then completes a full correct frame.
